// File: rtl/sdram_bridge_pkg.sv
// Shared types and default sizing for the SDRAM master bridge.
// cmd_t fixes the address/data widths, so the bridge parameters must match these defaults.
package sdram_bridge_pkg;
    localparam int DEF_ADDR_W      = 26;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_MAX_PENDING = 4;

    typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} bridge_state_t;

    typedef struct packed {
        op_t                   op;
        logic [DEF_ADDR_W-1:0] address;
        logic [DEF_DATA_W-1:0] writedata;
    } cmd_t;
endpackage

// File: rtl/sdram_master_bridge_if.sv
// Avalon-MM bus between the bridge (master) and the SDRAM controller (slave).
// Handshake: a command driven by the master completes in the first cycle with avm_waitrequest low.
interface sdram_master_bridge_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with a show-ahead head; push when full and pop when empty are ignored.
module cmd_fifo
    import sdram_bridge_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i_push,
    input  cmd_t                       i_push_cmd,
    input  logic                       i_pop,
    output cmd_t                       o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_cmd;
    end
endmodule

// File: rtl/sdram_master_bridge.sv
// Core SDRAM request strobes to Avalon-MM master: command FIFO, issue FSM,
// outstanding-read tracking, registered read return and sticky error flags.
module sdram_master_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int MAX_PENDING = DEF_MAX_PENDING
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               clear,
    input  logic                               req_read,
    input  logic                               req_write,
    input  logic [ADDR_W-1:0]                  req_address,
    input  logic [DATA_W-1:0]                  req_writedata,
    output logic                               req_ready,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               rd_valid,
    sdram_master_bridge_if.master              avm,
    output logic                               idle,
    output logic                               err_overflow,
    output logic                               err_unexpected,
    output logic                               err_both,
    output bridge_state_t                      o_dbg_state,
    output logic [$clog2(MAX_PENDING+1)-1:0]   o_dbg_pending
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    bridge_state_t     r_state, w_state_next;
    cmd_t              r_cmd, w_head, w_push_cmd;
    logic              r_read, r_write;
    logic [PEND_W-1:0] r_pending, w_pend_next;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full, w_fifo_empty, w_fifo_empty_next;
    logic              w_any_req, w_push, w_load;
    logic              w_complete, w_rd_done, w_ret, w_unexp, w_issuable;
    logic              r_rd_valid, r_idle;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err_overflow, r_err_unexpected, r_err_both;

    assign w_any_req  = req_read | req_write;
    assign req_ready  = ~w_fifo_full;
    assign w_push     = w_any_req & req_ready;
    // A write wins when both strobes are raised together.
    assign w_push_cmd = '{op: (req_write ? OP_WRITE : OP_READ),
                          address: req_address, writedata: req_writedata};

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_push     (w_push),
        .i_push_cmd (w_push_cmd),
        .i_pop      (w_load),
        .o_head     (w_head),
        .o_count    (w_fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign w_complete  = (r_state == BUSY) & ~avm.avm_waitrequest;
    assign w_rd_done   = w_complete & r_read;
    assign w_ret       = avm.avm_readdatavalid & (r_pending != '0);
    assign w_unexp     = avm.avm_readdatavalid & (r_pending == '0);
    assign w_pend_next = r_pending + PEND_W'(w_rd_done) - PEND_W'(w_ret);
    // Read issue uses next-cycle pending so the read completing now is counted.
    assign w_issuable  = ~w_fifo_empty &
                         ((w_head.op == OP_WRITE) | (w_pend_next < PEND_W'(MAX_PENDING)));

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issuable) begin
                    w_state_next = BUSY;
                    w_load       = 1'b1;
                end
            end
            BUSY: begin
                if (w_complete) begin
                    if (w_issuable) w_load = 1'b1;
                    else            w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state <= IDLE;
            r_cmd   <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_cmd   <= w_head;
                r_read  <= (w_head.op == OP_READ);
                r_write <= (w_head.op == OP_WRITE);
            end else if (w_state_next == IDLE) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
            end
        end
    end

    assign w_fifo_empty_next =
        ((w_fifo_count + CNT_W'(w_push) - CNT_W'(w_load)) == '0);

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_pending        <= '0;
            r_rd_valid       <= 1'b0;
            r_rd_data        <= '0;
            r_idle           <= 1'b1;
            r_err_overflow   <= 1'b0;
            r_err_unexpected <= 1'b0;
            r_err_both       <= 1'b0;
        end else begin
            r_pending  <= w_pend_next;
            r_rd_valid <= w_ret;
            if (w_ret) r_rd_data <= avm.avm_readdata;
            r_idle <= w_fifo_empty_next & (w_state_next == IDLE) & (w_pend_next == '0);
            // A new error event outranks a simultaneous clear.
            r_err_overflow   <= (w_any_req & ~req_ready) | (r_err_overflow & ~clear);
            r_err_unexpected <= w_unexp | (r_err_unexpected & ~clear);
            r_err_both       <= (req_read & req_write) | (r_err_both & ~clear);
        end
    end

    assign avm.avm_address    = r_cmd.address;
    assign avm.avm_writedata  = r_cmd.writedata;
    assign avm.avm_read       = r_read;
    assign avm.avm_write      = r_write;
    assign avm.avm_byteenable = (r_read | r_write) ? 4'hF : 4'h0;

    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign idle           = r_idle;
    assign err_overflow   = r_err_overflow;
    assign err_unexpected = r_err_unexpected;
    assign err_both       = r_err_both;
    assign o_dbg_state    = r_state;
    assign o_dbg_pending  = r_pending;
endmodule

// File: tb/tb_sdram_master_bridge.sv
// Bench for sdram_master_bridge: directed scenarios plus randomized traffic against
// a command scoreboard, an in-order return model and an outstanding-read count.
module tb_sdram_master_bridge;
  import sdram_bridge_pkg::*;

  localparam int MAX_PEND = 4;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic        clear = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [25:0] req_address = '0;
  logic [31:0] req_writedata = '0;
  logic        req_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        idle;
  logic        err_overflow;
  logic        err_unexpected;
  logic        err_both;
  bridge_state_t dbg_state;
  logic [2:0]  dbg_pending;

  sdram_master_bridge_if #(.ADDR_W(26), .DATA_W(32)) avm_if ();

  sdram_master_bridge dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (clear),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_writedata  (req_writedata),
    .req_ready      (req_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .avm            (avm_if),
    .idle           (idle),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected),
    .err_both       (err_both),
    .o_dbg_state    (dbg_state),
    .o_dbg_pending  (dbg_pending)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int outstanding = 0;
  int rv_count = 0;
  logic [59:0] exp_q[$];
  logic [31:0] ret_data_q[$];
  int          ret_due_q[$];
  logic [31:0] got_rd_q[$];
  logic        rv_exp = 1'b0;
  logic [31:0] rv_exp_data = '0;
  logic        held = 1'b0;
  logic [59:0] held_vec = '0;
  logic        mon_en = 1'b0;
  int          wait_mode = 2;   // 0 random, 1 stall, 2 no stall
  logic        ret_en = 1'b1;
  int          ret_lat = 0;     // 0 selects a random latency
  logic        fixed_data = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: monitor + slave model at negedge, then return at posedge+1.
  task automatic cycle();
    logic        cmd;
    logic        rdv_now;
    logic [59:0] got_v;
    logic [59:0] bus_v;
    int          due;
    @(negedge clk);
    cyc++;
    cmd   = avm_if.avm_read | avm_if.avm_write;
    bus_v = {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata};
    if (mon_en) begin
      check_eq("pending", 64'(dbg_pending), 64'(outstanding));
      if (rd_valid || rv_exp) begin
        check_eq("rd_valid", 64'(rd_valid), 64'(rv_exp));
        if (rv_exp) check_eq("rd_data", rd_data, rv_exp_data);
      end
      if (rd_valid) begin
        rv_count++;
        got_rd_q.push_back(rd_data);
      end
      check_eq("byteen", avm_if.avm_byteenable, cmd ? 4'hF : 4'h0);
      if (held) check_eq("hold", bus_v, held_vec);
    end
    case (wait_mode)
      0:       avm_if.avm_waitrequest = ($urandom_range(0, 3) == 0);
      1:       avm_if.avm_waitrequest = 1'b1;
      default: avm_if.avm_waitrequest = 1'b0;
    endcase
    rdv_now = 1'b0;
    if (ret_en && ret_due_q.size() > 0 && ret_due_q[0] <= cyc) begin
      rdv_now = 1'b1;
      avm_if.avm_readdata = ret_data_q.pop_front();
      void'(ret_due_q.pop_front());
    end else begin
      avm_if.avm_readdata = $urandom();
    end
    avm_if.avm_readdatavalid = rdv_now;
    rv_exp = 1'b0;
    if (n_rst) begin
      outstanding = 0;
      held = 1'b0;
      exp_q.delete();
    end else begin
      if (rdv_now) begin
        if (outstanding > 0) begin
          outstanding--;
          rv_exp = 1'b1;
          rv_exp_data = avm_if.avm_readdata;
        end
      end
      if (cmd && !avm_if.avm_waitrequest) begin
        held = 1'b0;
        got_v = {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address,
                 avm_if.avm_write ? avm_if.avm_writedata : 32'h0};
        if (exp_q.size() == 0) check_eq("cmd_extra", 64'(exp_q.size()), 64'd1);
        else check_eq("cmd", got_v, exp_q.pop_front());
        if (avm_if.avm_read) begin
          outstanding++;
          check_eq("pend_max", 64'(outstanding <= MAX_PEND), 64'd1);
          due = cyc + ((ret_lat != 0) ? ret_lat : $urandom_range(1, 6));
          if (ret_due_q.size() > 0 && due < ret_due_q[$]) due = ret_due_q[$];
          ret_due_q.push_back(due);
          ret_data_q.push_back(fixed_data ? 32'h90 + 32'(avm_if.avm_address) : $urandom());
        end
      end else if (cmd) begin
        held = 1'b1;
        held_vec = bus_v;
      end else begin
        held = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver: present one request for one cycle, record it if accepted
  task automatic drive_req(input logic rd, input logic wr, input logic [25:0] addr,
                           input logic [31:0] data);
    req_read = rd;
    req_write = wr;
    req_address = addr;
    req_writedata = data;
    if ((rd || wr) && req_ready)
      exp_q.push_back({~wr, wr, addr, wr ? data : 32'h0});
    cycle();
    req_read = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 300 && !(exp_q.size() == 0 && ret_due_q.size() == 0 && idle)) begin
      cycle();
      k++;
    end
    check_eq("drain_idle", 64'(idle), 64'd1);
    check_eq("drain_cmds", 64'(exp_q.size()), 64'd0);
    cycle();
  endtask

  initial begin
    int n;
    int rv0;
    avm_if.avm_waitrequest = 1'b0;
    avm_if.avm_readdata = '0;
    avm_if.avm_readdatavalid = 1'b0;

    // reset
    cycle();
    mon_en = 1'b1;
    cycle();
    n_rst = 1'b0;
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_bus", {avm_if.avm_read, avm_if.avm_write, avm_if.avm_byteenable}, 6'h0);
    check_eq("rst_rd", {rd_valid, rd_data}, 33'h0);
    check_eq("rst_err", {err_overflow, err_unexpected, err_both}, 3'b000);
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));

    // single write held by waitrequest for three cycles
    wait_mode = 1;
    drive_req(1'b0, 1'b1, 26'h0000100, 32'hDEADBEEF);
    check_eq("wr_lat0", 64'(avm_if.avm_write), 64'd0);
    check_eq("wr_idle0", 64'(idle), 64'd0);
    cycle();
    check_eq("wr_lat1", 64'(avm_if.avm_write), 64'd1);
    for (int i = 0; i < 3; i++) cycle();
    wait_mode = 2;
    cycle();
    check_eq("wr_done_bus", 64'(avm_if.avm_write), 64'd0);
    check_eq("wr_done_idle", 64'(idle), 64'd1);
    check_eq("wr_done_q", 64'(exp_q.size()), 64'd0);

    // four back-to-back reads, slave returns after five cycles
    ret_lat = 5;
    fixed_data = 1'b1;
    got_rd_q.delete();
    for (int i = 0; i < 4; i++) drive_req(1'b1, 1'b0, 26'h10 + 26'(i), $urandom());
    for (int i = 0; i < 15; i++) cycle();
    check_eq("rd4_cnt", 64'(got_rd_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_rd_q.size()) check_eq("rd4_data", got_rd_q[i], 32'hA0 + 32'(i));
    drain();

    // six reads with no returns: pending limit holds the fifth
    ret_en = 1'b0;
    ret_lat = 1;
    for (int i = 0; i < 6; i++) drive_req(1'b1, 1'b0, 26'h200 + 26'(i), $urandom());
    for (int i = 0; i < 4; i++) cycle();
    check_eq("six_issued", 64'(outstanding), 64'd4);
    check_eq("six_left", 64'(exp_q.size()), 64'd2);
    check_eq("six_r5_wait", 64'(avm_if.avm_read), 64'd0);
    ret_en = 1'b1;
    cycle();
    check_eq("six_r5_issue", 64'(avm_if.avm_read), 64'd1);
    drain();

    // overflow under constant stall
    wait_mode = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (!req_ready) break;
      drive_req(1'b0, 1'b1, 26'h300 + 26'(i), $urandom());
      n++;
    end
    check_eq("fill_cnt", 64'(n), 64'd5);
    check_eq("fill_ready", 64'(req_ready), 64'd0);
    check_eq("ovf_pre", 64'(err_overflow), 64'd0);
    drive_req(1'b0, 1'b1, 26'h3FF, 32'h12345678);
    check_eq("ovf_set", 64'(err_overflow), 64'd1);
    pulse_clear();
    check_eq("ovf_clear", 64'(err_overflow), 64'd0);
    wait_mode = 2;
    drain();

    // both strobes: only the write goes out
    drive_req(1'b1, 1'b1, 26'h2AA, 32'hCAFEF00D);
    check_eq("both_flag", 64'(err_both), 64'd1);
    drain();
    pulse_clear();
    check_eq("both_clear", 64'(err_both), 64'd0);

    // reset with two reads pending
    ret_en = 1'b0;
    rv0 = rv_count;
    drive_req(1'b1, 1'b0, 26'h40, $urandom());
    drive_req(1'b1, 1'b0, 26'h41, $urandom());
    for (int i = 0; i < 4; i++) cycle();
    check_eq("rst_pend2", 64'(outstanding), 64'd2);
    n_rst = 1'b1;
    cycle();
    n_rst = 1'b0;
    ret_en = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check_eq("rst_no_rdv", 64'(rv_count - rv0), 64'd0);
    check_eq("rst_unexp", 64'(err_unexpected), 64'd1);
    check_eq("rst_pend0", 64'(dbg_pending), 64'd0);
    check_eq("rst_left", 64'(ret_due_q.size()), 64'd0);
    pulse_clear();
    check_eq("unexp_clear", 64'(err_unexpected), 64'd0);

    // randomized traffic
    wait_mode = 0;
    ret_lat = 0;
    fixed_data = 1'b0;
    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0 || !req_ready) cycle();
      else drive_req(sel == 1, sel != 1, 26'($urandom()), $urandom());
    end
    drain();
    check_eq("rand_err", {err_overflow, err_unexpected, err_both}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
